// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral family: command layout,
// FSM state encoding and the default status byte.
package spi_pkg;

  localparam int CMD_READ_BIT = 7;
  localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_e;

  // MSB-first shift-in of one serial bit.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_i);
    return {cur[6:0], bit_i};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus single-cycle rise/fall
// pulses derived from the synchronized level.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] metastability stage, [1] synchronized level, [2] previous level
  logic [2:0] pipe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= 3'b000;
    end else begin
      pipe_q <= {pipe_q[1:0], din_i};
    end
  end

  assign sync_o = pipe_q[1];
  assign rise_o = pipe_q[1] & ~pipe_q[2];
  assign fall_o = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-file responder: command byte selects read/write and
// start address, followed by an auto-incrementing burst of data bytes.
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 4,
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  output logic [7:0]            user_rdata,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rx_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_meta_q, mosi_sync_q;

  spi_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic [7:0]            tx_shift_q, tx_shift_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;

  logic [7:0]            regs_q [DEPTH];
  logic [7:0]            rx_byte;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  byte_done;
  logic                  reg_we;

  logic                  wr_strobe_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_data_q;
  logic                  rx_done_q;
  logic [7:0]            user_rdata_q;

  spi_sync_edge u_sck_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (spi_clk),
    .sync_o (sck_sync),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (cs),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Same two-flop depth as the edge detectors so the MOSI level lines up with sck_rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign rx_byte  = shift_in(rx_shift_q, mosi_sync_q);
  assign cmd_addr = rx_byte[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
      addr_q     <= '0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    byte_done  = 1'b0;
    reg_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = CMD;
          tx_shift_d = STATUS_BYTE;
          bit_cnt_d  = 3'd0;
        end
      end
      default: begin
        if (cs_rise) begin
          // A partially received byte is simply dropped here.
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
          rx_shift_d = rx_byte;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            if (state_q == CMD) begin
              state_d = DATA;
              rw_d    = rx_byte[CMD_READ_BIT];
              if (rx_byte[CMD_READ_BIT]) begin
                tx_shift_d = regs_q[cmd_addr];
                addr_d     = cmd_addr + 1'b1;
              end else begin
                tx_shift_d = 8'h00;
                addr_d     = cmd_addr;
              end
            end else if (rw_q) begin
              tx_shift_d = regs_q[addr_q];
              addr_d     = addr_q + 1'b1;
            end else begin
              reg_we     = 1'b1;
              tx_shift_d = 8'h00;
              addr_d     = addr_q + 1'b1;
            end
          end
        end else if (sck_fall && bit_cnt_q != 3'd0) begin
          // Holding at bit_cnt 0 keeps a freshly loaded MSB on the line.
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
    endcase
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        regs_q[gi] <= 8'h00;
      end else if (reg_we && addr_q == ADDR_WIDTH'(gi)) begin
        regs_q[gi] <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
      rx_done_q    <= 1'b0;
      user_rdata_q <= 8'h00;
    end else begin
      wr_strobe_q  <= reg_we;
      rx_done_q    <= byte_done;
      user_rdata_q <= regs_q[user_addr];
      if (reg_we) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
    end
  end

  // The level itself is unused; only its edges drive the FSM.
  logic unused_sck_level;
  assign unused_sck_level = sck_sync & cs_sync;

  assign miso       = (state_q != IDLE) & tx_shift_q[7];
  assign user_rdata = user_rdata_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rx_done    = rx_done_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed plus randomized bench for spi_reg_slave, checked against a
// transaction-level register-file model.
module tb_spi_reg_slave;

  localparam int AW   = 4;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_clk;
  logic          cs;
  logic          mosi;
  logic          miso;
  logic [AW-1:0] user_addr;
  logic [7:0]    user_rdata;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rx_done;

  spi_reg_slave #(.ADDR_WIDTH(AW), .STATUS_BYTE(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso),
    .user_addr  (user_addr),
    .user_rdata (user_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rx_done    (rx_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]    mregs [16];
  logic [11:0]   exp_wr [$];
  logic [11:0]   wr_q [$];
  int            rx_cnt = 0;
  logic [7:0]    tx_buf [8];
  logic [7:0]    rx_buf [8];
  logic [7:0]    exp_rx [8];

  always @(negedge clk) begin
    if (wr_strobe) wr_q.push_back({wr_addr, wr_data});
    if (rx_done) rx_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(HALF);
      rx[7-i] = miso;
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  // Reference: status byte first; reads return the model, writes return 0 and update it.
  task automatic model_txn(input int n);
    logic [3:0] a;
    a = tx_buf[0][3:0];
    exp_rx[0] = 8'hA5;
    exp_wr.delete();
    for (int b = 1; b < n; b++) begin
      if (tx_buf[0][7]) begin
        exp_rx[b] = mregs[a];
      end else begin
        exp_rx[b] = 8'h00;
        mregs[a] = tx_buf[b];
        exp_wr.push_back({a, tx_buf[b]});
      end
      a = a + 4'd1;
    end
  endtask

  task automatic run_txn(input int n, input string tag);
    logic [7:0] r;
    model_txn(n);
    wr_q.delete();
    rx_cnt = 0;
    cs = 1'b0;
    wait_clk(HALF);
    for (int b = 0; b < n; b++) begin
      send_bits(tx_buf[b], 8, r);
      rx_buf[b] = r;
    end
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(2 * HALF);
    for (int b = 0; b < n; b++)
      check($sformatf("%s_rx%0d", tag, b), {24'h0, rx_buf[b]}, {24'h0, exp_rx[b]});
    check($sformatf("%s_nwr", tag), wr_q.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wr_q.size(); k++)
      check($sformatf("%s_wr%0d", tag, k), {20'h0, wr_q[k]}, {20'h0, exp_wr[k]});
    check($sformatf("%s_rxdone", tag), rx_cnt, n);
  endtask

  task automatic read_user(input logic [3:0] a, input string tag);
    user_addr = a;
    wait_clk(2);
    check($sformatf("%s_ur%0d", tag, a), {24'h0, user_rdata}, {24'h0, mregs[a]});
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) read_user(4'(a), tag);
  endtask

  initial begin
    logic [7:0] r;
    int n;
    reset = 1'b1; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0; user_addr = '0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_wrs", {31'h0, wr_strobe}, 32'h0);
    check("rst_rxd", {31'h0, rx_done}, 32'h0);
    check("rst_wraddr", {28'h0, wr_addr}, 32'h0);
    check("rst_wrdata", {24'h0, wr_data}, 32'h0);
    sweep("rst");

    // Write burst
    tx_buf[0] = 8'h02; tx_buf[1] = 8'hB7; tx_buf[2] = 8'h11;
    run_txn(3, "wrb");
    check("wrb_hold_addr", {28'h0, wr_addr}, 32'h3);
    check("wrb_hold_data", {24'h0, wr_data}, 32'h11);
    read_user(4'd3, "wrb");
    read_user(4'd2, "wrb");

    // Read burst
    tx_buf[0] = 8'h82; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    run_txn(3, "rdb");

    // Address wrap
    tx_buf[0] = 8'h0F; tx_buf[1] = 8'hAD; tx_buf[2] = 8'h89;
    run_txn(3, "wrap");
    read_user(4'd15, "wrap");
    read_user(4'd0, "wrap");

    // Aborted partial byte
    wr_q.delete(); rx_cnt = 0;
    cs = 1'b0; wait_clk(HALF);
    send_bits(8'h05, 8, r);
    send_bits(8'hFF, 4, r);
    wait_clk(HALF); cs = 1'b1; wait_clk(2 * HALF);
    check("abort_nwr", wr_q.size(), 0);
    check("abort_rxdone", rx_cnt, 1);
    read_user(4'd5, "abort");
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h3C;
    run_txn(2, "after_abort");
    read_user(4'd5, "after_abort");

    // Reset during the second data byte of a write
    cs = 1'b0; wait_clk(HALF);
    send_bits(8'h06, 8, r);
    send_bits(8'h12, 8, r);
    send_bits(8'h34, 4, r);
    reset = 1'b1; wait_clk(2); reset = 1'b0; wait_clk(3);
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    check("mrst_miso", {31'h0, miso}, 32'h0);
    check("mrst_wraddr", {28'h0, wr_addr}, 32'h0);
    check("mrst_wrdata", {24'h0, wr_data}, 32'h0);
    check("mrst_wrs", {31'h0, wr_strobe}, 32'h0);
    sweep("mrst");
    wait_clk(HALF); cs = 1'b1; wait_clk(2 * HALF);
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
    run_txn(2, "post_rst");

    // Aliased address, back-to-back transactions
    tx_buf[0] = 8'h73; tx_buf[1] = 8'h5E;
    run_txn(2, "alias_wr");
    tx_buf[0] = 8'h83; tx_buf[1] = 8'h00;
    run_txn(2, "alias_rd");

    // Random bursts
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 5);
      tx_buf[0] = 8'($urandom);
      for (int b = 1; b < n; b++) tx_buf[b] = 8'($urandom);
      run_txn(n, $sformatf("rnd%0d", t));
    end
    sweep("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI mode-0 responder that fronts a small register file, addressed by an 8-bit command byte from `spi_master`. It sits on the peripheral side of the SPI link, oversampling `spi_clk`, `mosi` and `cs` in the system clock domain. Multi-byte bursts with address auto-increment are supported in both directions. Local logic reads the register file through a registered port and sees every SPI write as a one-cycle strobe.

## Interface
- `ADDR_WIDTH`, 4: register-file address bits; depth = 2**ADDR_WIDTH, 8-bit registers.
- `STATUS_BYTE`, 8'hA5: byte shifted out on `miso` during the command byte.

- `clk`  in  1  system clock; all logic in this domain.
- `reset`  in  1  synchronous, active-high; clears everything listed under Operation.
- `spi_clk`  in  1  SPI clock from master, asynchronous, idle low.
- `cs`  in  1  chip select, active low, asynchronous.
- `mosi`  in  1  master data, MSB first.
- `miso`  out  1  slave data, MSB first; driven 0 while `cs` high (no tri-state).
- `user_addr`  in  ADDR_WIDTH  local read address.
- `user_rdata`  out  8  register at `user_addr`, registered.
- `wr_strobe`  out  1  one-cycle pulse per completed SPI write byte.
- `wr_addr`  out  ADDR_WIDTH  address of that write; held until the next write.
- `wr_data`  out  8  data of that write; held until the next write.
- `rx_done`  out  1  one-cycle pulse per completed byte of any kind, command included.

## Operation
- `spi_clk`, `cs` and `mosi` pass through 2-FF synchronizers. Edge detect on the synchronized `spi_clk`/`cs`: rise = MOSI sample, fall = MISO shift.
- Command byte: bit 7 = 1 read, 0 write; bits [ADDR_WIDTH-1:0] = start address. Bits between ADDR_WIDTH and 6 are ignored, so addresses alias.
- FSM states:
  - IDLE → CMD on synchronized `cs` fall. Same cycle: load `tx_shift` with STATUS_BYTE, `bit_cnt` = 0.
  - CMD → DATA on the 8th rise. Latch `rw` and `addr`. If read, load `tx_shift` with `reg[cmd addr]`, then `addr` = `cmd addr` + 1.
  - DATA stays DATA per byte:
    - Write: on the 8th rise, `reg[addr]` = received byte, `wr_strobe` pulses, `addr` += 1.
    - Read: on the 8th rise, `tx_shift` = `reg[addr]`, `addr` += 1.
  - Any state → IDLE on synchronized `cs` rise. A partial byte is discarded: no write, no `rx_done`.
- `addr` wraps from 2**ADDR_WIDTH-1 to 0.
- `miso` = `tx_shift[7]` while `cs` is low. A falling edge shifts left only when `bit_cnt` != 0, so the MSB of a freshly loaded byte holds until the first rise of the next byte.
- A read burst after a write burst returns the written values: register-file writes complete before the next read load.
- `user_rdata` <= `reg[user_addr]` every cycle. If an SPI write to the same address lands in the same cycle, the old value is returned; the new value appears one cycle later.
- Reset values: all registers 0, FSM IDLE, `bit_cnt` 0, `addr` 0, `tx_shift` 0, `miso` 0, `user_rdata` 0, `wr_strobe` 0, `wr_addr` 0, `wr_data` 0, `rx_done` 0. Reset mid-transfer aborts; the next transfer starts only after a fresh `cs` fall.

## Timing
- Synchronizer plus edge detect: 3 `clk` from the pin edge to the internal event.
- Requirements on the master: `spi_clk` high and low phases each ≥ 4 `clk`; `cs` fall to first `spi_clk` rise ≥ 4 `clk`; last fall to `cs` rise ≥ 4 `clk`.
- `wr_strobe` and `rx_done` assert 3-4 `clk` after the 8th pin-level `spi_clk` rise of a byte.
- `miso` changes 3-4 `clk` after the pin-level `spi_clk` fall, and after the `cs` fall for the first bit.
- `user_rdata`: 1-cycle latency.

## Structure
- Package `spi_pkg`:
  - `CMD_READ_BIT` = 7.
  - FSM state typedef: IDLE, CMD, DATA.
  - Default STATUS_BYTE constant, shared with future SPI peripherals.
- Sub-module `spi_sync_edge`: 2-FF synchronizer plus rise/fall pulses. Instantiated for `spi_clk` and `cs`; `mosi` uses only the synchronizer path.
- Register file: flat array, no separate module.

## Test plan
- Write burst: cmd 8'h02, data 8'hB7, 8'h11 → `wr_strobe` twice with (2, B7) then (3, 11). `user_addr` = 3 gives `user_rdata` = 8'h11. Master receives A5, 00, 00.
- Read burst: preload reg[2..3] = B7, 11 via SPI; then cmd 8'h82 plus two dummy bytes → master rx A5, B7, 11. No `wr_strobe`.
- Wrap: cmd 8'h0F, data 8'hAD, 8'h89 → reg[15] = AD, reg[0] = 89.
- Aborted byte: cmd 8'h05, 4 data bits, then `cs` high → no `wr_strobe`, reg[5] unchanged. Next full write to 5 succeeds.
- Reset mid-burst: assert `reset` during the 2nd data byte of a write → all outputs and registers 0. Following read cmd 8'h80 with one dummy byte returns A5, 00.
- Alias/back-to-back: cmd 8'h73 (address bits = 3) writes reg[3]. Immediately following `cs` low cycle with 8'h83 reads the value back.
